// File: rtl/ucie_ctl_tx_buffer.sv
// Transmit elastic buffer between the FDI adapter side and the RDI physical-layer side.
// A DEPTH-entry FIFO feeds a registered output stage with valid/ready handshaking on both sides.
module ucie_ctl_tx_buffer #(
    parameter int NBYTES = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_buffer_en,
    input  logic                     i_flush,
    input  logic [NBYTES-1:0]        i_fdi_lp_data,
    input  logic                     i_fdi_lp_valid,
    output logic                     o_fdi_pl_trdy,
    output logic [NBYTES-1:0]        o_rdi_lp_data,
    output logic                     o_rdi_lp_valid,
    input  logic                     i_rdi_pl_trdy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow_detected
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NBYTES-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NBYTES-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;

    logic              full_s;
    logic              empty_s;
    logic              trdy_s;
    logic              wr_en_s;
    logic              ld_en_s;

    // Handshake qualifiers; full blocks writes even if a load frees a slot on the same edge.
    always_comb begin
        full_s  = (count_q == CW'(DEPTH));
        empty_s = (count_q == {CW{1'b0}});
        trdy_s  = i_buffer_en & ~i_flush & ~full_s;
        wr_en_s = i_fdi_lp_valid & trdy_s;
        ld_en_s = i_buffer_en & ~i_flush & ~empty_s & (~out_valid_q | i_rdi_pl_trdy);
    end

    // Next-state for pointers, occupancy, output stage and sticky overflow flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (i_flush) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {CW{1'b0}};
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (ld_en_s) begin
                rd_ptr_d    = rd_ptr_q + AW'(1);
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
            end else if (out_valid_q & i_rdi_pl_trdy) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end

            case ({wr_en_s, ld_en_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (i_fdi_lp_valid & i_buffer_en & full_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control and output-stage state, cleared asynchronously by the active-low reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_data_q  <= {NBYTES{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage array; left unreset since occupancy alone says which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= i_fdi_lp_data;
        end
    end

    assign o_fdi_pl_trdy       = trdy_s;
    assign o_rdi_lp_data       = out_data_q;
    assign o_rdi_lp_valid      = out_valid_q;
    assign o_count             = count_q;
    assign o_full              = full_s;
    assign o_empty             = empty_s;
    assign o_overflow_detected = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_tx_buffer.sv
// Randomized and directed bench for ucie_ctl_tx_buffer, checked against a queue-based model.
module tb_ucie_ctl_tx_buffer;

    localparam int NB = 8;
    localparam int DP = 4;

    logic          i_clk;
    logic          i_rst;
    logic          i_buffer_en;
    logic          i_flush;
    logic [NB-1:0] i_fdi_lp_data;
    logic          i_fdi_lp_valid;
    logic          o_fdi_pl_trdy;
    logic [NB-1:0] o_rdi_lp_data;
    logic          o_rdi_lp_valid;
    logic          i_rdi_pl_trdy;
    logic [2:0]    o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow_detected;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model: the FIFO as a queue plus the output word
    logic [NB-1:0] mq[$];
    logic          mv;
    logic [NB-1:0] md;
    logic          movf;

    ucie_ctl_tx_buffer #(.NBYTES(NB), .DEPTH(DP)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_buffer_en         (i_buffer_en),
        .i_flush             (i_flush),
        .i_fdi_lp_data       (i_fdi_lp_data),
        .i_fdi_lp_valid      (i_fdi_lp_valid),
        .o_fdi_pl_trdy       (o_fdi_pl_trdy),
        .o_rdi_lp_data       (o_rdi_lp_data),
        .o_rdi_lp_valid      (o_rdi_lp_valid),
        .i_rdi_pl_trdy       (i_rdi_pl_trdy),
        .o_count             (o_count),
        .o_full              (o_full),
        .o_empty             (o_empty),
        .o_overflow_detected (o_overflow_detected)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("count", 64'(o_count), 64'(mq.size()));
        check_val("full", 64'(o_full), 64'(mq.size() == DP));
        check_val("empty", 64'(o_empty), 64'(mq.size() == 0));
        check_val("valid", 64'(o_rdi_lp_valid), 64'(mv));
        check_val("ovf", 64'(o_overflow_detected), 64'(movf));
        if (mv) begin
            check_val("data", 64'(o_rdi_lp_data), 64'(md));
        end
    endtask

    // One clock: drive at negedge, check ready, advance model at posedge, check at next negedge
    task automatic step(input logic en, input logic fl, input logic v,
                        input logic [NB-1:0] d, input logic rt, output logic acc);
        logic ld;
        logic full;
        i_buffer_en    = en;
        i_flush        = fl;
        i_fdi_lp_valid = v;
        i_fdi_lp_data  = d;
        i_rdi_pl_trdy  = rt;
        #1;
        full = (mq.size() == DP);
        check_val("trdy", 64'(o_fdi_pl_trdy), 64'(en & ~fl & ~full));
        @(posedge i_clk);
        acc = 1'b0;
        if (fl) begin
            mq.delete();
            mv   = 1'b0;
            movf = 1'b0;
        end else begin
            acc = v & en & ~full;
            ld  = en & (mq.size() > 0) & (~mv | rt);
            if (v & en & full) movf = 1'b1;
            if (ld) begin
                md = mq.pop_front();
                mv = 1'b1;
            end else if (mv & rt) begin
                mv = 1'b0;
            end
            if (acc) mq.push_back(d);
        end
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic put(input logic [NB-1:0] d, input logic rt);
        logic acc;
        step(1'b1, 1'b0, 1'b1, d, rt, acc);
    endtask

    task automatic idle(input logic en, input logic rt, input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 8'h00, rt, acc);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   budget;

        mv = 1'b0; md = 8'h00; movf = 1'b0;
        i_rst = 1'b0; i_buffer_en = 1'b0; i_flush = 1'b0;
        i_fdi_lp_valid = 1'b0; i_fdi_lp_data = 8'h00; i_rdi_pl_trdy = 1'b0;
        #12;
        check_outputs();
        check_val("rst_data", 64'(o_rdi_lp_data), 64'h0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Basic pass: no bypass, one-cycle latency into the output stage
        put(8'hA1, 1'b1);
        check_val("basic_n", 64'(o_rdi_lp_valid), 64'h0);
        idle(1'b1, 1'b1, 1);
        check_val("basic_n1_v", 64'(o_rdi_lp_valid), 64'h1);
        check_val("basic_n1_d", 64'(o_rdi_lp_data), 64'hA1);
        idle(1'b1, 1'b1, 1);
        check_val("basic_n2_v", 64'(o_rdi_lp_valid), 64'h0);

        // Backpressure until full, overflow, then drain in order
        for (int i = 1; i <= 6; i++) put(NB'(i), 1'b0);
        check_val("bp_full", 64'(o_full), 64'h1);
        check_val("bp_ovf", 64'(o_overflow_detected), 64'h1);
        check_val("bp_held", 64'(o_rdi_lp_data), 64'h01);
        idle(1'b1, 1'b1, 6);

        // Flush clears the overflow left by the previous scenario
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, acc);

        // Wrap-around with output readiness toggling every cycle
        sent = 0;
        budget = 0;
        while (sent < 16 && budget < 200) begin
            step(1'b1, 1'b0, 1'b1, NB'(sent), budget[0], acc);
            if (acc) sent++;
            budget++;
        end
        check_val("wrap_sent", 64'(sent), 64'd16);
        idle(1'b1, 1'b1, 6);

        // Simultaneous write and load at occupancy 2
        put(8'h10, 1'b0); put(8'h11, 1'b0); put(8'h12, 1'b0);
        check_val("sim_pre", 64'(o_count), 64'd2);
        put(8'h13, 1'b1);
        check_val("sim_post", 64'(o_count), 64'd2);
        idle(1'b1, 1'b1, 5);

        // Flush with 3 buffered plus a valid output word
        for (int i = 0; i < 4; i++) put(NB'(8'h20 + i), 1'b0);
        check_val("fl_pre", 64'(o_count), 64'd3);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, acc);
        check_val("fl_cnt", 64'(o_count), 64'd0);
        check_val("fl_v", 64'(o_rdi_lp_valid), 64'h0);
        check_val("fl_ovf", 64'(o_overflow_detected), 64'h0);
        put(8'h77, 1'b1);
        idle(1'b1, 1'b1, 1);
        check_val("fl_first", 64'(o_rdi_lp_data), 64'h77);
        idle(1'b1, 1'b1, 2);

        // Disabled buffer: held word completes, FIFO content retained
        put(8'h30, 1'b0); put(8'h31, 1'b0); put(8'h32, 1'b0);
        idle(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, acc);
        check_val("dis_v", 64'(o_rdi_lp_valid), 64'h0);
        check_val("dis_cnt", 64'(o_count), 64'd2);
        idle(1'b0, 1'b1, 2);
        idle(1'b1, 1'b1, 4);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7), NB'($urandom), ($urandom_range(0, 1) == 1), acc);
        end

        // Reset mid-transfer discards everything buffered
        for (int i = 0; i < 4; i++) put(NB'(8'h40 + i), 1'b0);
        i_rst = 1'b0;
        #1;
        mq.delete(); mv = 1'b0; md = 8'h00; movf = 1'b0;
        check_outputs();
        check_val("mrst_data", 64'(o_rdi_lp_data), 64'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        put(8'h55, 1'b1);
        idle(1'b1, 1'b1, 1);
        check_val("mrst_first", 64'(o_rdi_lp_data), 64'h55);
        idle(1'b1, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
